mips_dmem_resp: RTL and testbench

MIPS_DMEM_RESP -- requirements
Module: mips_dmem_resp

---
 rtl/mips_dmem_pkg.sv | 50 +++++
 rtl/btn_sync_edge.sv | 45 ++++
 rtl/mips_dmem_resp.sv | 169 ++++++++++++++++
 tb/tb_mips_dmem_resp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_dmem_pkg.sv
// Shared definitions for the MIPS data-memory responder: the I/O address map,
// register offsets, TCTRL/BTN bit positions and the address decoder.
package mips_dmem_pkg;

  localparam logic [31:0] IO_BASE    = 32'hFFFF_0000;
  localparam logic [7:0]  OFF_LED    = 8'h00;
  localparam logic [7:0]  OFF_BTN    = 8'h04;
  localparam logic [7:0]  OFF_TCOUNT = 8'h08;
  localparam logic [7:0]  OFF_TCMP   = 8'h0C;
  localparam logic [7:0]  OFF_TCTRL  = 8'h10;

  localparam int TCTRL_EN_BIT    = 0;
  localparam int TCTRL_AC_BIT    = 1;
  localparam int TCTRL_MATCH_BIT = 8;

  localparam int BTN_COUNT      = 4;
  localparam int BTN_LEVEL_LSB  = 0;
  localparam int BTN_STICKY_LSB = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_BTN,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_TCTRL
  } dmem_sel_e;

  // True when a word address matches an I/O register at the given offset.
  function automatic logic ioHit(input logic [31:0] addr, input logic [7:0] off);
    logic [31:0] full;
    full = IO_BASE | {24'h0, off};
    return addr[31:2] == full[31:2];
  endfunction

  // Maps a CPU byte address onto the region it selects; bits [1:0] are ignored.
  function automatic dmem_sel_e decodeAddr(input logic [31:0] addr);
    dmem_sel_e sel;
    sel = SEL_NONE;
    if (addr[31:16] == 16'h0000)     sel = SEL_RAM;
    else if (ioHit(addr, OFF_LED))    sel = SEL_LED;
    else if (ioHit(addr, OFF_BTN))    sel = SEL_BTN;
    else if (ioHit(addr, OFF_TCOUNT)) sel = SEL_TCOUNT;
    else if (ioHit(addr, OFF_TCMP))   sel = SEL_TCMP;
    else if (ioHit(addr, OFF_TCTRL))  sel = SEL_TCTRL;
    return sel;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// One pushbutton lane: two-flop synchroniser, an extra delayed copy for
// rising-edge detection, and a sticky rise flag cleared by a write-one strobe.
module btn_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  input  logic clr_i,
  output logic level_o,
  output logic sticky_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic sticky_q;
  logic sticky_d;
  logic rise;

  // Sticky next state: a fresh rising edge beats a clear in the same cycle.
  always_comb begin
    rise     = sync2_q & ~prev_q;
    sticky_d = sticky_q;
    if (rise)       sticky_d = 1'b1;
    else if (clr_i) sticky_d = 1'b0;
  end

  // Synchroniser chain, edge-detect delay and sticky flag, all cleared on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      sticky_q <= sticky_d;
    end
  end

  assign level_o  = sync2_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/mips_dmem_resp.sv
// Data-memory responder for a single-cycle MIPS: word RAM with zero-latency
// reads plus memory-mapped LED, button and (optionally) timer registers.
// The timer block is compiled in only when MIPS_DMEM_TIMER_EN is defined;
// otherwise its addresses read as zero and irq comes from the buttons alone.
module mips_dmem_resp
  import mips_dmem_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int TIMER_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [15:0] led,
  input  logic [3:0]  btn,
  output logic        irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  dmem_sel_e                 sel;
  logic [IDX_W-1:0]          ramIdx;
  logic [31:0]               ram_q [RAM_WORDS];
  logic [15:0]               led_q;
  logic                      irq_q;
  logic                      irq_d;
  logic                      wrRam;
  logic                      wrLed;
  logic                      wrBtn;
  logic [BTN_COUNT-1:0]      btnLevel;
  logic [BTN_COUNT-1:0]      btnSticky;
  logic                      unusedAddrBits;

  assign sel    = decodeAddr(memaddr);
  assign ramIdx = memaddr[IDX_W+1:2];
  assign wrRam  = memwrite && (sel == SEL_RAM) && !reset;
  assign wrLed  = memwrite && (sel == SEL_LED);
  assign wrBtn  = memwrite && (sel == SEL_BTN);

  assign unusedAddrBits = ^{memaddr[1:0], memaddr[15:IDX_W+2]};

  // Four identical button lanes; a W1C write strobes the matching sticky bit.
  for (genvar i = 0; i < BTN_COUNT; i++) begin : gBtn
    btn_sync_edge uBtn (
      .clk_i    (clk),
      .reset_i  (reset),
      .btn_i    (btn[i]),
      .clr_i    (wrBtn && memwritedata[BTN_STICKY_LSB+i]),
      .level_o  (btnLevel[i]),
      .sticky_o (btnSticky[i])
    );
  end

  // RAM store; contents deliberately survive reset, but reset blocks a coincident store.
  always_ff @(posedge clk) begin
    if (wrRam) ram_q[ramIdx] <= memwritedata;
  end

  // LED register takes the low half-word of a store.
  always_ff @(posedge clk) begin
    if (reset)      led_q <= '0;
    else if (wrLed) led_q <= memwritedata[15:0];
  end

`ifdef MIPS_DMEM_TIMER_EN
  logic [TIMER_W-1:0] tCount_q;
  logic [TIMER_W-1:0] tCount_d;
  logic [TIMER_W-1:0] tCmp_q;
  logic [TIMER_W-1:0] tCmp_d;
  logic               tEnable_q;
  logic               tEnable_d;
  logic               tAutoClr_q;
  logic               tAutoClr_d;
  logic               tMatch_q;
  logic               tMatch_d;
  logic               timerMatch;
  logic               wrTCount;
  logic               wrTCmp;
  logic               wrTCtrl;

  assign wrTCount = memwrite && (sel == SEL_TCOUNT);
  assign wrTCmp   = memwrite && (sel == SEL_TCMP);
  assign wrTCtrl  = memwrite && (sel == SEL_TCTRL);

  // Timer next state: CPU write beats autoclear, which beats the increment;
  // a new match beats a same-cycle W1C of the match flag.
  always_comb begin
    tCount_d   = tCount_q;
    tCmp_d     = tCmp_q;
    tEnable_d  = tEnable_q;
    tAutoClr_d = tAutoClr_q;
    tMatch_d   = tMatch_q;
    timerMatch = tEnable_q && (tCount_q == tCmp_q);

    if (wrTCount)                      tCount_d = memwritedata[TIMER_W-1:0];
    else if (timerMatch && tAutoClr_q) tCount_d = '0;
    else if (tEnable_q)                tCount_d = tCount_q + TIMER_W'(1);

    if (wrTCmp) tCmp_d = memwritedata[TIMER_W-1:0];

    if (wrTCtrl) begin
      tEnable_d  = memwritedata[TCTRL_EN_BIT];
      tAutoClr_d = memwritedata[TCTRL_AC_BIT];
    end

    if (timerMatch)                                    tMatch_d = 1'b1;
    else if (wrTCtrl && memwritedata[TCTRL_MATCH_BIT]) tMatch_d = 1'b0;
  end

  // Timer registers; reset restarts the timer disabled at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      tCount_q   <= '0;
      tCmp_q     <= '0;
      tEnable_q  <= 1'b0;
      tAutoClr_q <= 1'b0;
      tMatch_q   <= 1'b0;
    end else begin
      tCount_q   <= tCount_d;
      tCmp_q     <= tCmp_d;
      tEnable_q  <= tEnable_d;
      tAutoClr_q <= tAutoClr_d;
      tMatch_q   <= tMatch_d;
    end
  end

  assign irq_d = tMatch_q | (|btnSticky);
`else
  logic [TIMER_W-1:0] unusedTimerW;
  assign unusedTimerW = '0;
  assign irq_d = |btnSticky;
`endif

  // Interrupt line is registered, so it trails the flags by one cycle.
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  // Zero-latency read mux; unmapped addresses read as zero.
  always_comb begin
    memreaddata = '0;
    case (sel)
      SEL_RAM: memreaddata = ram_q[ramIdx];
      SEL_LED: memreaddata[15:0] = led_q;
      SEL_BTN: begin
        memreaddata[BTN_LEVEL_LSB +: BTN_COUNT]  = btnLevel;
        memreaddata[BTN_STICKY_LSB +: BTN_COUNT] = btnSticky;
      end
`ifdef MIPS_DMEM_TIMER_EN
      SEL_TCOUNT: memreaddata[TIMER_W-1:0] = tCount_q;
      SEL_TCMP:   memreaddata[TIMER_W-1:0] = tCmp_q;
      SEL_TCTRL: begin
        memreaddata[TCTRL_EN_BIT]    = tEnable_q;
        memreaddata[TCTRL_AC_BIT]    = tAutoClr_q;
        memreaddata[TCTRL_MATCH_BIT] = tMatch_q;
      end
`endif
      default: memreaddata = '0;
    endcase
  end

  assign led = led_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_mips_dmem_resp.sv
// Directed self-checking bench for mips_dmem_resp. Timer checks are built
// only when MIPS_DMEM_TIMER_EN is defined; otherwise the timer addresses are
// checked to behave as unmapped.
module tb_mips_dmem_resp;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_BTN    = 32'hFFFF_0004;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_0008;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_000C;
  localparam logic [31:0] A_TCTRL  = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [15:0] led;
  logic [3:0]  btn;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mips_dmem_resp #(.RAM_WORDS(64), .TIMER_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .led          (led),
    .btn          (btn),
    .irq          (irq)
  );

  // Free-running clock, 20 time units per period.
  always #10 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, let the rising edge take it, then release memwrite.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    memwrite     = we;
    memaddr      = addr;
    memwritedata = data;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  // Idle clock cycles with no store.
  task automatic idleCycles(input int n);
    memwrite = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Combinational read probe between clock edges.
  task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    memwrite = 1'b0;
    memaddr  = addr;
    #1;
    checkOutput(tag, memreaddata, exp);
  endtask

  initial begin
    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = '0;
    memwritedata = '0;
    btn          = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_led_port", {16'h0, led}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkRead("rst_led_rd", A_LED, 32'h0);
    checkRead("rst_btn_rd", A_BTN, 32'h0);

    $display("[TB] RAM");
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    checkRead("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    checkRead("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h0000_0020, 32'h0123_4567);
    memaddr      = 32'h0000_0020;
    memwritedata = 32'h89AB_CDEF;
    memwrite     = 1'b1;
    #1;
    checkOutput("ram_old_same_cycle", memreaddata, 32'h0123_4567);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    checkRead("ram_new", 32'h0000_0020, 32'h89AB_CDEF);
    applyStimulus(1'b1, 32'h0000_0000, 32'h1111_1111);
    applyStimulus(1'b1, 32'h0001_0000, 32'h2222_2222);
    checkRead("ram_unmapped_wr", 32'h0000_0000, 32'h1111_1111);
    checkRead("unmapped_rd", 32'h0001_0000, 32'h0);

    $display("[TB] LED");
    applyStimulus(1'b1, A_LED, 32'h1234_ABCD);
    checkOutput("led_port", {16'h0, led}, 32'h0000_ABCD);
    checkRead("led_rd", A_LED, 32'h0000_ABCD);
    checkRead("gap_rd", 32'hFFFF_0020, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_0020, 32'hFFFF_FFFF);
    checkOutput("gap_wr_ignored", {16'h0, led}, 32'h0000_ABCD);

    $display("[TB] buttons");
    btn = 4'b0100;
    idleCycles(2);
    checkRead("btn_level", A_BTN, 32'h04);
    idleCycles(1);
    checkRead("btn_sticky", A_BTN, 32'h44);
    checkOutput("irq_lag", {31'h0, irq}, 32'h0);
    idleCycles(1);
    checkOutput("irq_set", {31'h0, irq}, 32'h1);
    applyStimulus(1'b1, A_BTN, 32'h40);
    checkRead("btn_w1c", A_BTN, 32'h04);
    idleCycles(1);
    checkOutput("irq_clear", {31'h0, irq}, 32'h0);
    btn = 4'b0101;
    idleCycles(2);
    checkRead("btn0_level", A_BTN, 32'h05);
    applyStimulus(1'b1, A_BTN, 32'h10);
    checkRead("btn_set_wins", A_BTN, 32'h15);
    applyStimulus(1'b1, A_BTN, 32'h10);
    checkRead("btn0_w1c", A_BTN, 32'h05);

`ifdef MIPS_DMEM_TIMER_EN
    $display("[TB] timer");
    applyStimulus(1'b1, A_TCMP, 32'd5);
    applyStimulus(1'b1, A_TCTRL, 32'h3);
    checkRead("tcount_start", A_TCOUNT, 32'd0);
    idleCycles(5);
    checkRead("tcount_5", A_TCOUNT, 32'd5);
    checkRead("tctrl_pre", A_TCTRL, 32'h003);
    idleCycles(1);
    checkRead("tcount_autoclr", A_TCOUNT, 32'd0);
    checkRead("tctrl_match", A_TCTRL, 32'h103);
    checkOutput("irq_timer_lag", {31'h0, irq}, 32'h0);
    idleCycles(1);
    checkOutput("irq_timer", {31'h0, irq}, 32'h1);
    applyStimulus(1'b1, A_TCTRL, 32'h100);
    checkRead("tctrl_w1c", A_TCTRL, 32'h000);
    idleCycles(1);
    checkOutput("irq_timer_clr", {31'h0, irq}, 32'h0);
    checkRead("tcount_hold", A_TCOUNT, 32'd2);

    $display("[TB] timer boundaries");
    applyStimulus(1'b1, A_TCOUNT, 32'hFFFF_FFFF);
    applyStimulus(1'b1, A_TCMP, 32'h10);
    applyStimulus(1'b1, A_TCTRL, 32'h1);
    checkRead("tcount_max", A_TCOUNT, 32'hFFFF_FFFF);
    idleCycles(1);
    checkRead("tcount_wrap", A_TCOUNT, 32'h0);
    applyStimulus(1'b1, A_TCOUNT, 32'h10);
    checkRead("tcount_wr_override", A_TCOUNT, 32'h10);
    idleCycles(1);
    checkRead("tctrl_match2", A_TCTRL, 32'h101);
    checkRead("tcount_no_autoclr", A_TCOUNT, 32'h11);
    applyStimulus(1'b1, A_TCOUNT, 32'h10);
    applyStimulus(1'b1, A_TCTRL, 32'h101);
    checkRead("match_set_wins", A_TCTRL, 32'h101);
    checkRead("tcount_after", A_TCOUNT, 32'h11);
`else
    $display("[TB] timer addresses unmapped");
    applyStimulus(1'b1, A_TCOUNT, 32'hFFFF_FFFF);
    applyStimulus(1'b1, A_TCMP, 32'hFFFF_FFFF);
    applyStimulus(1'b1, A_TCTRL, 32'hFFFF_FFFF);
    idleCycles(2);
    checkRead("tcount_unmapped", A_TCOUNT, 32'h0);
    checkRead("tcmp_unmapped", A_TCMP, 32'h0);
    checkRead("tctrl_unmapped", A_TCTRL, 32'h0);
    checkOutput("irq_btn_only", {31'h0, irq}, 32'h0);
`endif

    $display("[TB] reset mid-run");
    memaddr      = A_LED;
    memwritedata = 32'h0000_FFFF;
    memwrite     = 1'b1;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    memwrite = 1'b0;
    checkOutput("rst2_led_port", {16'h0, led}, 32'h0);
    checkOutput("rst2_irq", {31'h0, irq}, 32'h0);
    checkRead("rst2_btn", A_BTN, 32'h0);
    checkRead("rst2_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
`ifdef MIPS_DMEM_TIMER_EN
    checkRead("rst2_tcount", A_TCOUNT, 32'h0);
    checkRead("rst2_tcmp", A_TCMP, 32'h0);
    checkRead("rst2_tctrl", A_TCTRL, 32'h0);
    idleCycles(2);
    checkRead("rst2_timer_off", A_TCOUNT, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
